// File: rtl/bit_pattern_generator_pkg.sv
// Shared types and defaults for the thermometer-pattern generator.
// Optional overflow flag is enabled by defining BITGEN_OVF_FLAG_EN.
package bitgen_pkg;

   localparam int BITGEN_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUILD = 2'd1,
      DONE  = 2'd2
   } bitgen_state_t;

endpackage

// File: rtl/bit_pattern_generator_if.sv
// Request/result bundle between a pattern requester (master) and the generator (slave).
// The overflow signal exists only when BITGEN_OVF_FLAG_EN is defined.
interface bit_pattern_generator_if #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) ();

   logic             start;
   logic [CW-1:0]    count_in;
   logic [WIDTH-1:0] pattern;
   logic             busy;
   logic             done;
`ifdef BITGEN_OVF_FLAG_EN
   logic             overflow;
`endif

   modport master (
      output start,
      output count_in,
      input  pattern,
      input  busy,
      input  done
`ifdef BITGEN_OVF_FLAG_EN
      ,
      input  overflow
`endif
   );

   modport slave (
      input  start,
      input  count_in,
      output pattern,
      output busy,
      output done
`ifdef BITGEN_OVF_FLAG_EN
      ,
      output overflow
`endif
   );

endinterface

// File: rtl/bit_pattern_generator_datapath.sv
// Pattern and remaining-count registers with the count clamp; driven by load/shift from the FSM.
// Overflow register present only when BITGEN_OVF_FLAG_EN is defined.
module bitgen_datapath
   import bitgen_pkg::*;
#(
   parameter int WIDTH = BITGEN_W,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [CW-1:0]    count_i,
   output logic [WIDTH-1:0] pattern_o,
   output logic             rem_zero,
`ifdef BITGEN_OVF_FLAG_EN
   output logic             overflow_o,
`endif
   output logic [CW-1:0]    rem_o
);

   localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);

   logic [WIDTH-1:0] pattern_q, pattern_d;
   logic [CW-1:0]    rem_q, rem_d;
   logic [CW-1:0]    count_clamped;
   logic             over_range;

   // Requests beyond the word width saturate to an all-ones pattern.
   assign over_range    = (count_i > WIDTH_CW);
   assign count_clamped = over_range ? WIDTH_CW : count_i;

   always_comb begin
      pattern_d = pattern_q;
      rem_d     = rem_q;
      if (load) begin
         pattern_d = '0;
         rem_d     = count_clamped;
      end else if (shift) begin
         pattern_d = {pattern_q[WIDTH-2:0], 1'b1};
         rem_d     = rem_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pattern_q <= '0;
         rem_q     <= '0;
      end else begin
         pattern_q <= pattern_d;
         rem_q     <= rem_d;
      end
   end

`ifdef BITGEN_OVF_FLAG_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (load) begin
         ovf_d = over_range;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign overflow_o = ovf_q;
`endif

   assign pattern_o = pattern_q;
   assign rem_zero  = (rem_q == '0);
   assign rem_o     = rem_q;

endmodule

// File: rtl/bit_pattern_generator.sv
// Serially builds a WIDTH-bit LSB-packed thermometer word holding min(count_in, WIDTH) ones.
// FSM here, registers in bitgen_datapath; BITGEN_OVF_FLAG_EN adds the overflow output.
module bit_pattern_generator
   import bitgen_pkg::*;
#(
   parameter int WIDTH = BITGEN_W,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   bit_pattern_generator_if.slave bus
);

   bitgen_state_t state_q, state_d;
   logic          load;
   logic          shift;
   logic          rem_zero;
   logic [CW-1:0] rem_unused;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = BUILD;
         BUILD:   if (rem_zero)  state_d = DONE;
         // A fresh request requires start to drop first.
         DONE:    if (!bus.start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load     = 1'b0;
      shift    = 1'b0;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      unique case (state_q)
         IDLE:    load = bus.start;
         BUILD: begin
            bus.busy = 1'b1;
            shift    = !rem_zero;
         end
         DONE:    bus.done = 1'b1;
         default: ;
      endcase
   end

   bitgen_datapath #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_datapath (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .shift      (shift),
      .count_i    (bus.count_in),
      .pattern_o  (bus.pattern),
      .rem_zero   (rem_zero),
`ifdef BITGEN_OVF_FLAG_EN
      .overflow_o (bus.overflow),
`endif
      .rem_o      (rem_unused)
   );

endmodule

// File: tb/tb_bit_pattern_generator.sv
// Directed bench for bit_pattern_generator: reset, build lengths, clamping, handshake hold, mid-build reset.
module tb_bit_pattern_generator;

   localparam int WIDTH = 8;
   localparam int CW    = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   bit_pattern_generator_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

   bit_pattern_generator #(.WIDTH(WIDTH), .CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle to the falling edge for sampling/driving.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Start edge, n shift edges with per-step pattern checks, then the DONE edge.
   task automatic build(input logic [3:0] cnt, input int n, input bit hold, input string tag);
      logic [31:0] thermo;
      bus.count_in = cnt;
      bus.start    = 1'b1;
      cyc();
      if (!hold) bus.start = 1'b0;
      bus.count_in = ~cnt;
      chk({tag, "_busy0"}, 32'(bus.busy), 32'd1);
      chk({tag, "_done0"}, 32'(bus.done), 32'd0);
      chk({tag, "_pat0"},  32'(bus.pattern), 32'h0);
      for (int i = 1; i <= n; i++) begin
         cyc();
         thermo = (32'h1 << i) - 32'h1;
         chk($sformatf("%s_pat%0d", tag, i), 32'(bus.pattern), thermo);
         chk($sformatf("%s_busy%0d", tag, i), 32'(bus.busy), 32'd1);
      end
      cyc();
      thermo = (32'h1 << n) - 32'h1;
      chk({tag, "_done"},     32'(bus.done), 32'd1);
      chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
      chk({tag, "_final"},    32'(bus.pattern), thermo);
   endtask

   initial begin
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.count_in = '0;
      cyc();
      cyc();
      chk("rst_pattern", 32'(bus.pattern), 32'h0);
      chk("rst_busy",    32'(bus.busy),    32'd0);
      chk("rst_done",    32'(bus.done),    32'd0);
`ifdef BITGEN_OVF_FLAG_EN
      chk("rst_ovf",     32'(bus.overflow), 32'd0);
`endif
      reset = 1'b0;
      cyc();
      chk("idle_busy", 32'(bus.busy), 32'd0);

      build(4'd0, 0, 1'b0, "n0");
      cyc();
      chk("n0_idle_done", 32'(bus.done), 32'd0);

      build(4'd3, 3, 1'b0, "n3");
      cyc();
      chk("n3_idle_done", 32'(bus.done), 32'd0);
      chk("n3_idle_pat",  32'(bus.pattern), 32'h07);

      build(4'd8, 8, 1'b0, "n8");
      cyc();
      chk("n8_idle_pat", 32'(bus.pattern), 32'hFF);

      build(4'd12, 8, 1'b0, "n12");
      chk("n12_pat", 32'(bus.pattern), 32'hFF);
`ifdef BITGEN_OVF_FLAG_EN
      chk("n12_ovf", 32'(bus.overflow), 32'd1);
`endif
      cyc();
      build(4'd2, 2, 1'b0, "n2");
      chk("n2_pat", 32'(bus.pattern), 32'h03);
`ifdef BITGEN_OVF_FLAG_EN
      chk("n2_ovf", 32'(bus.overflow), 32'd0);
`endif
      cyc();

      build(4'd15, 8, 1'b0, "n15");
      cyc();

      // start held through DONE: count_in changes must not restart a build.
      build(4'd5, 5, 1'b1, "hold");
      for (int i = 0; i < 5; i++) begin
         bus.count_in = 4'(i + 1);
         cyc();
         chk($sformatf("hold_done%0d", i), 32'(bus.done), 32'd1);
         chk($sformatf("hold_pat%0d", i),  32'(bus.pattern), 32'h1F);
         chk($sformatf("hold_busy%0d", i), 32'(bus.busy), 32'd0);
      end
      bus.start = 1'b0;
      cyc();
      chk("hold_idle_done", 32'(bus.done), 32'd0);
      chk("hold_idle_pat",  32'(bus.pattern), 32'h1F);
      build(4'd1, 1, 1'b0, "restart");
      cyc();

      // Reset on the third BUILD cycle abandons the request.
      bus.count_in = 4'd6;
      bus.start    = 1'b1;
      cyc();
      bus.start = 1'b0;
      cyc();
      cyc();
      chk("mid_pat_pre", 32'(bus.pattern), 32'h03);
      reset = 1'b1;
      cyc();
      chk("mid_pat",  32'(bus.pattern), 32'h0);
      chk("mid_busy", 32'(bus.busy), 32'd0);
      chk("mid_done", 32'(bus.done), 32'd0);
      reset = 1'b0;
      cyc();
      chk("mid_idle_busy", 32'(bus.busy), 32'd0);

      // reset and start together: reset wins.
      reset        = 1'b1;
      bus.start    = 1'b1;
      bus.count_in = 4'd4;
      cyc();
      chk("rs_busy", 32'(bus.busy), 32'd0);
      chk("rs_pat",  32'(bus.pattern), 32'h0);
      reset     = 1'b0;
      bus.start = 1'b0;
      cyc();
      chk("rs_idle", 32'(bus.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bit_pattern_generator.md
# bit_pattern_generator

Inverse of the lab's one-bit counter: takes a count N and serially builds a WIDTH-bit thermometer word containing exactly N ones, packed at the LSB end. It shifts one `1` in per cycle under a start/done handshake. Its controller and datapath follow the lab's ASM split. The block sits beside the bit counter so that benches and top-levels can generate patterns with a known ones-count and round-trip them through the counter.

## Interface
- `WIDTH`, default 8: pattern width in bits.
- `CW`, default `$clog2(WIDTH+1)` (4 for 8): width of `count_in` and of the internal remaining-count register.
- `clk`, input, 1: the block's only clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: level request; sampled in IDLE.
- `count_in`, input, CW: number of ones requested, sampled on the start edge.
- `pattern`, output, WIDTH: registered pattern under construction and the final result.
- `busy`, output, 1: high in BUILD.
- `done`, output, 1: high in DONE.
- `overflow`, output, 1: present only with `BITGEN_OVF_FLAG_EN` (see Configuration).

## Operation
- Reset values:
  - FSM returns to IDLE.
  - `pattern` = 0.
  - remaining-count = 0.
  - `busy` = 0, `done` = 0, `overflow` = 0.
- IDLE:
  - `start`=1 at an edge: remaining <= min(`count_in`, WIDTH), `pattern` <= 0, go to BUILD.
  - `start`=0: stay in IDLE. `pattern` keeps its last result.
- BUILD, remaining ≠ 0:
  - `pattern` <= {`pattern`[WIDTH-2:0], 1'b1}.
  - remaining <= remaining − 1.
  - Stay in BUILD.
- BUILD, remaining = 0:
  - Go to DONE; `pattern` is unchanged.
- DONE:
  - `done`=1 and `pattern` is held.
  - Stay in DONE while `start`=1.
  - `start`=0: go to IDLE.
- Handshake rules:
  - A new request needs `start` to be deasserted for at least one cycle.
  - `start` is ignored in BUILD.
  - `count_in` is ignored everywhere except on the IDLE start edge.
- Clamping:
  - `count_in` > WIDTH is clamped to WIDTH, so `pattern` saturates at all-ones.
  - Values between WIDTH+1 and 2^CW − 1 (9 to 15 for the defaults) all yield the all-ones pattern.
- Invariant: in DONE, the ones-count of `pattern` equals min(`count_in`, WIDTH), and `pattern` is a contiguous run of ones starting at bit 0.

## Timing
- Let E be the edge at which IDLE samples `start`=1.
- `busy` is high from E+1 through the cycle before `done` rises.
- `done` rises after edge E+N+1 (N = clamped count). The FSM leaves BUILD on edge E+N+1, and `done` is visible in the cycle that follows.
  - N = 0: `done` is high one cycle after `busy` rises.
  - N = 8: `done` rises 9 edges after E.
- During BUILD, `pattern` grows by one bit per edge. Intermediate values are visible but are not valid results.
- Reset asserted mid-BUILD or in DONE: on the next edge, all reset values apply, and any in-flight request is abandoned.
- `reset` and `start` high together: reset wins.

## Configuration
- Macro: `BITGEN_OVF_FLAG_EN`.
- Defined:
  - The `overflow` output exists.
  - It is registered on the start edge as (`count_in` > WIDTH).
  - It is held through BUILD and DONE, and cleared on the next accepted start or on reset.
- Undefined:
  - The port and its logic are absent.
  - Clamping still occurs, silently.

## Structure
- Package `bitgen_pkg`:
  - State enum `bitgen_state_t` {IDLE, BUILD, DONE}.
  - Default-width constant `BITGEN_W` = 8.
- Sub-module `bitgen_datapath`:
  - Holds the `pattern` and remaining registers plus the clamp comparator.
  - Control inputs: `load`, `shift`.
  - Status output: `rem_zero`.
- The top level holds the FSM and instantiates the datapath.

## Test plan
- Reset, then `count_in`=0 with `start` pulsed → `done`=1 with `pattern`=8'h00; `busy` high for exactly one cycle.
- `count_in`=3 → `pattern` steps 8'h01, 8'h03, 8'h07; `done` rises 4 edges after the start edge with `pattern`=8'h07.
- `count_in`=8 → `pattern`=8'hFF; `done` rises 9 edges after the start edge.
- `count_in`=12 → `pattern`=8'hFF. With `BITGEN_OVF_FLAG_EN`, `overflow`=1; a following request with `count_in`=2 clears it and yields 8'h03.
- Hold `start`=1 through DONE for 5 cycles, changing `count_in` → no restart and `pattern` unchanged. Drop `start` → IDLE; raise `start` again → a new build runs.
- `count_in`=6, assert `reset` on the 3rd BUILD cycle → next cycle shows `pattern`=0, `busy`=0, `done`=0, FSM in IDLE.
